fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Program-counter register and instruction-fetch sequencer, directly upstream of execution_control.
- Holds the architectural PC and fetches the word at PC from instruction memory over a req/ack handshake.
- Presents pc and instruction to execution_control for one execute window.
- Commits execution_control's next_pc when pc_write is asserted, then starts the next fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MAX_WAIT, 16, max cycles imem_req may stay unacknowledged before fault (range 1..255).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  leave IDLE/HALT and begin fetching at current pc
halt_req  input  1  stop after the current instruction commits
imem_req  output  1  instruction memory read request
imem_addr  output  32  fetch address (= pc while imem_req high)
imem_ack  input  1  read data valid on imem_rdata this cycle
imem_rdata  input  32  fetched instruction word
pc  output  32  current PC, to execution_control
instruction  output  32  latched instruction, to execution_control
instr_valid  output  1  pc/instruction valid for execution this cycle
pc_write  input  1  from execution_control: commit next_pc
next_pc  input  32  from execution_control
halted  output  1  high in HALT
fault  output  1  sticky fault flag
fault_code  output  2  0 none, 1 fetch timeout, 2 misaligned next_pc

Behaviour:
Reset values (async, rst_n low):
- state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instruction=0, instr_valid=0, halted=0, fault=0, fault_code=0, wait counter=0.
- Reset mid-WAIT drops imem_req immediately; the outstanding ack is not tracked.

States: IDLE, REQ, WAIT, EXEC, HALT, FAULT.
- IDLE: outputs idle. start=1 -> REQ.
- REQ: imem_req=1, imem_addr=pc, wait counter cleared.
  - imem_ack=1 same cycle -> instruction<=imem_rdata, -> EXEC (zero-wait memory: REQ to EXEC in 1 cycle).
  - else -> WAIT.
- WAIT: imem_req held 1, imem_addr stable at pc, counter increments each cycle.
  - imem_ack=1 -> latch instruction, -> EXEC.
  - Counter reaches MAX_WAIT without ack -> FAULT with fault_code=1; ack and timeout in the same cycle -> ack wins.
- EXEC: instr_valid=1, imem_req=0.
  - pc_write=0: stay in EXEC; pc, instruction and instr_valid held (stall).
  - pc_write=1 and next_pc[1:0]!=0: -> FAULT, fault_code=2, pc unchanged.
  - pc_write=1, aligned, halt_req=1: pc<=next_pc, -> HALT.
  - pc_write=1, aligned, halt_req=0: pc<=next_pc, -> REQ.
  - instr_valid is therefore high for exactly one cycle per committed instruction unless stalled.
- HALT: halted=1, imem_req=0, instr_valid=0, pc holds. start=1 -> REQ (resume at held pc).
- FAULT: fault=1, imem_req=0, instr_valid=0; sticky until rst_n.

Rules:
- halt_req in REQ/WAIT is not sampled; the fetch completes and the check is made at commit.
- halt_req in IDLE is ignored.
- imem_ack outside REQ/WAIT is ignored.
- start outside IDLE/HALT is ignored.
- pc arithmetic is 32-bit; no wrap check (0xFFFF_FFFC+4 -> 0 is legal).
- Steady state with a zero-wait memory: 2 cycles per instruction (REQ, EXEC).
- All outputs registered except imem_addr, which is driven from pc.

Optional Feature:
Macro IFU_PERF_COUNT_EN.
- Defined: adds outputs retired_count (32) and stall_cycles (32), both reset to 0 by rst_n.
  - retired_count increments on each EXEC commit (pc_write=1, aligned).
  - stall_cycles increments on each WAIT cycle and each EXEC cycle with pc_write=0.
  - Both wrap at 2^32 and freeze in HALT/FAULT.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, start=1, ack same cycle as req, rdata=0x2001_0005, pc_write=1, next_pc=4 -> imem_addr=0; instr_valid high 1 cycle with instruction=0x2001_0005; next imem_addr=4; 2 cycles/instruction.
- Ack delayed 3 cycles -> imem_req high 4 cycles with imem_addr stable; EXEC follows the ack; MAX_WAIT=4 with no ack -> fault=1, fault_code=1, imem_req=0, sticky.
- pc_write=0 for 5 cycles in EXEC -> instr_valid and pc held 5 cycles; pc_write=1, next_pc=0x40 -> next fetch at 0x40.
- next_pc=0x0000_0042 with pc_write=1 -> fault_code=2, pc unchanged, no further imem_req.
- halt_req during WAIT, commit next_pc=0x10 -> halted=1, pc=0x10; start=1 -> fetch at 0x10.
- rst_n low during WAIT -> imem_req=0 asynchronously, pc=RESET_PC; with IFU_PERF_COUNT_EN, 3 commits + 2 wait cycles -> retired_count=3, stall_cycles=2.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch sequencer feeding execution_control.
// Optional performance counters are enabled by defining IFU_PERF_COUNT_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        pc_write,
    input  logic [31:0] next_pc,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code
`ifdef IFU_PERF_COUNT_EN
    ,
    output logic [31:0] retired_count,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_TIMEOUT  = 2'd1;
    localparam logic [1:0] FC_MISALIGN = 2'd2;

    // Value the counter holds on the last permitted WAIT cycle: after
    // MAX_WAIT unacknowledged WAIT cycles the fetch is declared dead.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    assign imem_addr = pc;

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch below sees the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end

                S_REQ: begin
                    wait_cnt <= '0;
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_EXEC;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // An ack on the timeout cycle still completes the fetch.
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        imem_req   <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FC_TIMEOUT;
                        state      <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_EXEC: begin
                    if (pc_write) begin
                        instr_valid <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            fault      <= 1'b1;
                            fault_code <= FC_MISALIGN;
                            state      <= S_FAULT;
                        end else begin
                            pc <= next_pc;
                            if (halt_req) begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                imem_req <= 1'b1;
                                state    <= S_REQ;
                            end
                        end
                    end
                end

                S_HALT: begin
                    if (start) begin
                        halted   <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= S_REQ;
                    end
                end

                S_FAULT: begin
                    state <= S_FAULT;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IFU_PERF_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count <= '0;
            stall_cycles  <= '0;
        end else begin
            if (state == S_EXEC && pc_write && next_pc[1:0] == 2'b00) begin
                retired_count <= retired_count + 32'd1;
            end
            if (state == S_WAIT || (state == S_EXEC && !pc_write)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table, hand-written
// corner sequences and a randomized transaction-level run.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        pc_write;
    logic [31:0] next_pc;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
`ifdef IFU_PERF_COUNT_EN
    logic [31:0] retired_count;
    logic [31:0] stall_cycles;
`endif

    fetch_pc_unit #(
        .RESET_PC(32'h0000_0000),
        .MAX_WAIT(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt_req   (halt_req),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc_write   (pc_write),
        .next_pc    (next_pc),
        .halted     (halted),
        .fault      (fault),
        .fault_code (fault_code)
`ifdef IFU_PERF_COUNT_EN
        ,
        .retired_count(retired_count),
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level model state: what the next fetch address must be and
    // how many commits / stall cycles have occurred since the last reset.
    logic [31:0] exp_pc;
    int          exp_retired;
    int          exp_stall;

    typedef struct {
        int          lat;     // WAIT cycles before ack (0 = ack in REQ)
        int          stall;   // EXEC cycles with pc_write=0 before commit
        logic [31:0] rdata;
        logic [31:0] npc;
        logic [31:0] exp_pc;  // address the DUT must fetch for this entry
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        halt_req   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        pc_write   = 1'b0;
        next_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        exp_pc      = 32'h0;
        exp_retired = 0;
        exp_stall   = 0;
    endtask

    task automatic check_perf(input string name);
`ifdef IFU_PERF_COUNT_EN
        check({name, "_retired"}, retired_count, 32'(exp_retired));
        check({name, "_stall"}, stall_cycles, 32'(exp_stall));
`else
        if (name.len() == 0) $display("perf check with empty name");
`endif
    endtask

    task automatic kick_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // One full instruction: fetch with 'lat' wait cycles, then 'stall' EXEC
    // stall cycles, then commit npc. Noise is driven on inputs the DUT must ignore.
    task automatic run_instr(input int lat, input int stall, input logic [31:0] rdata,
                             input logic [31:0] npc, input bit do_halt);
        for (int c = 0; c <= lat; c++) begin
            check("fetch_req", imem_req, 1'b1);
            check("fetch_addr", imem_addr, exp_pc);
            check("fetch_valid", instr_valid, 1'b0);
            check("fetch_halted", halted, 1'b0);
            halt_req   = 1'($urandom_range(0, 1));
            imem_ack   = (c == lat);
            imem_rdata = (c == lat) ? rdata : $urandom;
            step();
        end
        for (int s = 0; s <= stall; s++) begin
            check("exec_valid", instr_valid, 1'b1);
            check("exec_instr", instruction, rdata);
            check("exec_pc", pc, exp_pc);
            check("exec_req", imem_req, 1'b0);
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            start      = 1'($urandom_range(0, 1));
            halt_req   = do_halt;
            pc_write   = (s == stall);
            next_pc    = (s == stall) ? npc : $urandom;
            step();
        end
        imem_ack    = 1'b0;
        start       = 1'b0;
        halt_req    = 1'b0;
        pc_write    = 1'b0;
        exp_pc      = npc;
        exp_retired = exp_retired + 1;
        exp_stall   = exp_stall + lat + stall;
    endtask

    initial begin
        tbl[0] = '{0, 0, 32'h2001_0005, 32'h0000_0004, 32'h0000_0000};
        tbl[1] = '{3, 0, 32'h1111_1111, 32'h0000_0008, 32'h0000_0004};
        tbl[2] = '{0, 5, 32'h2222_2222, 32'h0000_0040, 32'h0000_0008};
        tbl[3] = '{4, 1, 32'h3333_3333, 32'hFFFF_FFFC, 32'h0000_0040};
        tbl[4] = '{1, 0, 32'h4444_4444, 32'h0000_0000, 32'hFFFF_FFFC};
        tbl[5] = '{0, 2, 32'h5555_5555, 32'h0000_0100, 32'h0000_0000};

        // Reset state.
        do_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instruction, 32'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_code", fault_code, 2'd0);
        check_perf("rst");

        // halt_req and ack in IDLE are ignored.
        halt_req = 1'b1;
        imem_ack = 1'b1;
        step();
        check("idle_req", imem_req, 1'b0);
        check("idle_halted", halted, 1'b0);
        halt_req = 1'b0;
        imem_ack = 1'b0;

        // Directed vector table.
        kick_start();
        for (int i = 0; i < 6; i++) begin
            check("tbl_pc", exp_pc, tbl[i].exp_pc);
            run_instr(tbl[i].lat, tbl[i].stall, tbl[i].rdata, tbl[i].npc, 1'b0);
        end
        check_perf("tbl");

        // Misaligned next_pc: fault_code 2, pc unchanged, no further fetches.
        check("mis_req", imem_req, 1'b1);
        check("mis_addr", imem_addr, 32'h100);
        imem_ack   = 1'b1;
        imem_rdata = 32'h6666_6666;
        step();
        imem_ack = 1'b0;
        check("mis_valid", instr_valid, 1'b1);
        pc_write = 1'b1;
        next_pc  = 32'h0000_0042;
        step();
        pc_write = 1'b0;
        check("mis_fault", fault, 1'b1);
        check("mis_code", fault_code, 2'd2);
        check("mis_pc", pc, 32'h100);
        check("mis_valid_lo", instr_valid, 1'b0);
        start    = 1'b1;
        imem_ack = 1'b1;
        repeat (3) begin
            step();
            check("mis_sticky_req", imem_req, 1'b0);
            check("mis_sticky_fault", fault, 1'b1);
        end
        start    = 1'b0;
        imem_ack = 1'b0;

        // Fetch timeout with MAX_WAIT=4: REQ plus four WAIT cycles, then FAULT.
        do_reset();
        kick_start();
        for (int c = 0; c < 5; c++) begin
            check("to_req", imem_req, 1'b1);
            check("to_addr", imem_addr, 32'h0);
            step();
        end
        check("to_fault", fault, 1'b1);
        check("to_code", fault_code, 2'd1);
        check("to_req_lo", imem_req, 1'b0);
        start = 1'b1;
        repeat (2) step();
        start = 1'b0;
        check("to_sticky", fault, 1'b1);
        check("to_sticky_code", fault_code, 2'd1);
        check("to_sticky_req", imem_req, 1'b0);

        // Three commits with two wait cycles in total, then halt via halt_req.
        do_reset();
        kick_start();
        run_instr(0, 0, 32'hA000_0001, 32'h4, 1'b0);
        run_instr(2, 0, 32'hA000_0002, 32'h8, 1'b0);
        run_instr(0, 0, 32'hA000_0003, 32'hC, 1'b0);
        check_perf("perf3");
        run_instr(2, 1, 32'hA000_0004, 32'h10, 1'b1);
        check("halt_halted", halted, 1'b1);
        check("halt_pc", pc, 32'h10);
        check("halt_req_lo", imem_req, 1'b0);
        check("halt_valid", instr_valid, 1'b0);
        imem_ack = 1'b1;
        repeat (3) step();
        imem_ack = 1'b0;
        check("halt_hold", halted, 1'b1);
        check_perf("halt_frozen");
        kick_start();
        check("resume_halted", halted, 1'b0);
        check("resume_req", imem_req, 1'b1);
        check("resume_addr", imem_addr, 32'h10);

        // Async reset while a fetch is outstanding.
        step();
        check("wait_req", imem_req, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_req", imem_req, 1'b0);
        check("arst_pc", pc, 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_pc      = 32'h0;
        exp_retired = 0;
        exp_stall   = 0;
        check_perf("arst");

        // Randomized run against the transaction-level model.
        kick_start();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] r;
            logic [31:0] npc;
            bit          h;
            r   = $urandom;
            npc = ($urandom_range(0, 3) == 0) ? (r & 32'hFFFF_FFFC) : exp_pc + 32'd4;
            h   = ($urandom_range(0, 7) == 0);
            run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom, npc, h);
            if (h) begin
                check("rnd_halted", halted, 1'b1);
                check("rnd_halt_pc", pc, exp_pc);
                check_perf("rnd_halt");
                kick_start();
            end
        end
        check_perf("rnd_end");
        check("rnd_fault", fault, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
